conv_window_fetch: RTL and testbench

- Downstream consumer of the image page memory in the YOLO accelerator datapath.
- Walks a stored IMG_W x IMG_H frame of 8-bit pixels, issuing single-pixel reads to the page memory.
- Assembles each 3x3 neighbourhood into a 72-bit window.
- Hands each window to the convolution engine over a valid/ready handshake.

---
 rtl/yolo_img_pkg.sv | 21 ++
 rtl/window_addr_gen.sv | 97 +++++++++
 rtl/conv_window_fetch.sv | 124 ++++++++++++
 tb/tb_conv_window_fetch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_img_pkg.sv
// Shared image/window definitions for the YOLO window stages: pixel/window widths,
// the 3x3 slot index and the window-stage state encoding.
package yolo_img_pkg;

   localparam int PIX_W   = 8;
   localparam int WIN_PIX = 9;
   localparam int WIN_W   = PIX_W * WIN_PIX;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_LAST,
      PRESENT,
      DONE
   } win_state_t;

   function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
      return ({2'b00, r} * 4'd3) + {2'b00, c};
   endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window position and tap counters with an incrementally built page-memory address.
// CONV_WINDOW_PAD_EN switches to centre-addressed zero-padded windows with an in-bounds flag.
module window_addr_gen
   import yolo_img_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 640,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        r,
   output logic [1:0]        c,
   output logic [15:0]       x,
   output logic [15:0]       y,
   output logic              last_tap,
   output logic              last_win,
   output logic              in_bounds
);

`ifdef CONV_WINDOW_PAD_EN
   localparam logic [15:0]       X_LAST   = 16'(IMG_W - 1);
   localparam logic [15:0]       Y_LAST   = 16'(IMG_H - 1);
   // Base points one row up and one column left of the centre; wraps modulo 2^ADDR_W.
   localparam logic [ADDR_W-1:0] BASE0    = ADDR_W'(0) - ADDR_W'(IMG_W + 1);
   localparam logic [ADDR_W-1:0] ROW_WRAP = ADDR_W'(1);
`else
   localparam logic [15:0]       X_LAST   = 16'(IMG_W - 3);
   localparam logic [15:0]       Y_LAST   = 16'(IMG_H - 3);
   localparam logic [ADDR_W-1:0] BASE0    = '0;
   localparam logic [ADDR_W-1:0] ROW_WRAP = ADDR_W'(3);
`endif
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   logic [ADDR_W-1:0] base;

   assign last_tap = (r == 2'd2) && (c == 2'd2);
   assign last_win = (x == X_LAST) && (y == Y_LAST);

`ifdef CONV_WINDOW_PAD_EN
   logic row_out;
   logic col_out;
   assign row_out   = ((r == 2'd0) && (y == 16'd0)) || ((r == 2'd2) && (y == X_LAST - X_LAST + Y_LAST));
   assign col_out   = ((c == 2'd0) && (x == 16'd0)) || ((c == 2'd2) && (x == X_LAST));
   assign in_bounds = !(row_out || col_out);
`else
   assign in_bounds = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
         base <= '0;
         r    <= 2'd0;
         c    <= 2'd0;
         x    <= 16'd0;
         y    <= 16'd0;
      end else if (load) begin
         addr <= BASE0;
         base <= BASE0;
         r    <= 2'd0;
         c    <= 2'd0;
         x    <= 16'd0;
         y    <= 16'd0;
      end else if (step) begin
         if (last_tap) begin
            r    <= 2'd0;
            c    <= 2'd0;
            addr <= base;
         end else if (c == 2'd2) begin
            c    <= 2'd0;
            r    <= r + 2'd1;
            addr <= addr + ROW_STEP;
         end else begin
            c    <= c + 2'd1;
            addr <= addr + ONE;
         end
      end else if (advance) begin
         if (x == X_LAST) begin
            x    <= 16'd0;
            y    <= y + 16'd1;
            base <= base + ROW_WRAP;
            addr <= base + ROW_WRAP;
         end else begin
            x    <= x + 16'd1;
            base <= base + ONE;
            addr <= base + ONE;
         end
      end
   end

endmodule

// File: rtl/conv_window_fetch.sv
// Scans a stored frame, fetches each 3x3 neighbourhood pixel by pixel and presents it
// to the convolution engine. CONV_WINDOW_PAD_EN enables zero-padded, centre-addressed windows.
module conv_window_fetch
   import yolo_img_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 640,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [WIN_W-1:0]  win_data,
   output logic [15:0]       win_x,
   output logic [15:0]       win_y,
   output logic              win_valid,
   input  logic              win_ready,
   output logic              busy,
   output logic              done
);

   win_state_t state;
   win_state_t state_nxt;

   logic       load;
   logic       step;
   logic       advance;
   logic [1:0] r;
   logic [1:0] c;
   logic       last_tap;
   logic       last_win;
   logic       in_bounds;

   logic       cap_vld_p1;
   logic       cap_inb_p1;
   logic [3:0] cap_slot_p1;
   logic [PIX_W-1:0] pix_p2 [WIN_PIX];

   window_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .advance   (advance),
      .addr      (mem_addr),
      .r         (r),
      .c         (c),
      .x         (win_x),
      .y         (win_y),
      .last_tap  (last_tap),
      .last_win  (last_win),
      .in_bounds (in_bounds)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               load      = 1'b1;
            end
         end
         FETCH: begin
            step = 1'b1;
            if (last_tap) state_nxt = WAIT_LAST;
         end
         WAIT_LAST: state_nxt = PRESENT;
         PRESENT: begin
            if (win_ready) begin
               if (last_win) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = FETCH;
                  advance   = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // p1: remember which slot the read in flight belongs to; p2: land the returned pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_vld_p1  <= 1'b0;
         cap_inb_p1  <= 1'b0;
         cap_slot_p1 <= 4'd0;
         for (int i = 0; i < WIN_PIX; i++) pix_p2[i] <= '0;
      end else begin
         cap_vld_p1  <= (state == FETCH);
         cap_inb_p1  <= in_bounds;
         cap_slot_p1 <= idx(r, c);
         if (cap_vld_p1) pix_p2[cap_slot_p1] <= cap_inb_p1 ? mem_rdata : '0;
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < WIN_PIX; i++) win_data[i*PIX_W +: PIX_W] = pix_p2[i];
   end

   assign mem_rd    = (state == FETCH) && in_bounds;
   assign win_valid = (state == PRESENT);
   assign busy      = (state == FETCH) || (state == WAIT_LAST) || (state == PRESENT);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch on a 4x4 frame whose memory returns pixel = address;
// expected windows come from a table (or a padding model) through a scoreboard queue.
module tb_conv_window_fetch;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int ADDR_W = 8;
`ifdef CONV_WINDOW_PAD_EN
   localparam int NWIN       = IMG_W * IMG_H;
   localparam bit RESUME_RD  = 1'b0;
`else
   localparam int NWIN       = (IMG_W - 2) * (IMG_H - 2);
   localparam bit RESUME_RD  = 1'b1;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata;
   logic [71:0]       win_data;
   logic [15:0]       win_x;
   logic [15:0]       win_y;
   logic              win_valid;
   logic              win_ready;
   logic              busy;
   logic              done;

   typedef struct {
      int          x;
      int          y;
      logic [71:0] data;
   } win_rec_t;

   win_rec_t          frame_tbl [NWIN];
   win_rec_t          exp_q [$];
   win_rec_t          e;
   bit                rd_en   [9];
   logic [ADDR_W-1:0] rd_addr [9];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_hs = -10;
   int hs_cnt = 0;
   int done_cnt = 0;
   bit prev_hs = 1'b0;

   conv_window_fetch #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .win_data  (win_data),
      .win_x     (win_x),
      .win_y     (win_y),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Page memory: one-cycle read latency; idle cycles return a marker value.
   always @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'hEE;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [71:0] pad_win(input int x, input int y);
      logic [71:0] d;
      int rr, cc;
      d = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            rr = y + r - 1;
            cc = x + c - 1;
            if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
               d[8*(3*r+c) +: 8] = 8'(rr * IMG_W + cc);
         end
      return d;
   endfunction

   always @(negedge clk) begin
      if (prev_hs) check("valid_drop_after_accept", win_valid, 1'b0);
      prev_hs = 1'b0;
      if (win_valid && win_ready && !rst) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_window: got x=%0d y=%0d, required none", win_x, win_y);
         end else begin
            e = exp_q.pop_front();
            check("win_data", win_data, e.data);
            check("win_x", win_x, 72'(e.x));
            check("win_y", win_y, 72'(e.y));
         end
         last_hs = cyc;
         hs_cnt++;
         prev_hs = 1'b1;
      end
      if (done) begin
         check("done_one_after_last_accept", cyc, last_hs + 1);
         check("busy_low_at_done", busy, 1'b0);
         done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      for (int i = 0; i < NWIN; i++) exp_q.push_back(frame_tbl[i]);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_mem_rd"}, mem_rd, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, '0);
      check({tag, "_win_valid"}, win_valid, 1'b0);
      check({tag, "_win_data"}, win_data, '0);
      check({tag, "_win_x"}, win_x, '0);
      check({tag, "_win_y"}, win_y, '0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", seen, 1'b1);
      tick();
      @(negedge clk);
      check("busy_after_done", busy, 1'b0);
      check("queue_empty", exp_q.size(), 0);
   endtask

   // First-window read sequence and latency, then the rest of the frame with ready high.
   task automatic run_checked_frame();
      hs_cnt = 0;
      push_frame();
      win_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check($sformatf("fetch%0d_mem_rd", k), mem_rd, rd_en[k]);
         check($sformatf("fetch%0d_busy", k), busy, 1'b1);
         if (rd_en[k]) check($sformatf("fetch%0d_mem_addr", k), mem_addr, rd_addr[k]);
         tick();
      end
      @(negedge clk);
      check("wait_last_mem_rd", mem_rd, 1'b0);
      check("wait_last_win_valid", win_valid, 1'b0);
      tick();
      @(negedge clk);
      check("first_win_valid", win_valid, 1'b1);
      wait_done(500);
      check("window_count", hs_cnt, NWIN);
   endtask

   initial begin
      bit seen;
      int dc;
      rst = 1'b1;
      start = 1'b0;
      win_ready = 1'b0;

`ifdef CONV_WINDOW_PAD_EN
      for (int i = 0; i < NWIN; i++) begin
         frame_tbl[i].x = i % IMG_W;
         frame_tbl[i].y = i / IMG_W;
         frame_tbl[i].data = pad_win(i % IMG_W, i / IMG_W);
      end
      for (int k = 0; k < 9; k++) begin
         rd_en[k] = 1'b0;
         rd_addr[k] = '0;
      end
      rd_en[4] = 1'b1; rd_addr[4] = 8'd0;
      rd_en[5] = 1'b1; rd_addr[5] = 8'd1;
      rd_en[7] = 1'b1; rd_addr[7] = 8'd4;
      rd_en[8] = 1'b1; rd_addr[8] = 8'd5;
`else
      frame_tbl[0] = '{x: 0, y: 0, data: 72'h0A_09_08_06_05_04_02_01_00};
      frame_tbl[1] = '{x: 1, y: 0, data: 72'h0B_0A_09_07_06_05_03_02_01};
      frame_tbl[2] = '{x: 0, y: 1, data: 72'h0E_0D_0C_0A_09_08_06_05_04};
      frame_tbl[3] = '{x: 1, y: 1, data: 72'h0F_0E_0D_0B_0A_09_07_06_05};
      rd_addr[0] = 8'd0; rd_addr[1] = 8'd1; rd_addr[2] = 8'd2;
      rd_addr[3] = 8'd4; rd_addr[4] = 8'd5; rd_addr[5] = 8'd6;
      rd_addr[6] = 8'd8; rd_addr[7] = 8'd9; rd_addr[8] = 8'd10;
      for (int k = 0; k < 9; k++) rd_en[k] = 1'b1;
`endif

      repeat (3) tick();
      @(negedge clk);
      check_idle("reset");
      tick();
      rst = 1'b0;
      tick();

      // First window timing plus a full frame with ready held high.
      run_checked_frame();

      // Backpressure for five cycles, with start pulses during FETCH and PRESENT.
      hs_cnt = 0;
      push_frame();
      win_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (win_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("bp_valid_seen", seen, 1'b1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("bp%0d_win_valid", i), win_valid, 1'b1);
         check($sformatf("bp%0d_win_data", i), win_data, frame_tbl[0].data);
         check($sformatf("bp%0d_win_x", i), win_x, 72'(frame_tbl[0].x));
         check($sformatf("bp%0d_win_y", i), win_y, 72'(frame_tbl[0].y));
         check($sformatf("bp%0d_mem_rd", i), mem_rd, 1'b0);
         tick();
         start = (i == 1);
         if (i == 4) win_ready = 1'b1;
      end
      @(negedge clk);
      check("bp_accept_valid", win_valid, 1'b1);
      tick();
      start = 1'b1;
      @(negedge clk);
      check("bp_resume_win_valid", win_valid, 1'b0);
      check("bp_resume_busy", busy, 1'b1);
      check("bp_resume_mem_rd", mem_rd, RESUME_RD);
      tick();
      start = 1'b0;
      wait_done(500);
      check("bp_window_count", hs_cnt, NWIN);

      // Reset on the fourth FETCH cycle aborts the scan without a done pulse.
      hs_cnt = 0;
      dc = done_cnt;
      win_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle("abort");
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check($sformatf("abort%0d_mem_rd", i), mem_rd, 1'b0);
         check($sformatf("abort%0d_busy", i), busy, 1'b0);
      end
      check("abort_no_done", done_cnt, dc);
      check("abort_no_window", hs_cnt, 0);
      tick();
      run_checked_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
